atm_keypad_entry: RTL

Keypad front-end for the ATM controller. Collects decimal key presses into a digit buffer, converts them to binary on ENTER, and hands the main ATM state machine a validated PIN (`password`), account number (`Pers_Account_No`) or amount (`withdraw_amount` / `Transfer_Amount`). It sits directly upstream of the ATM FSM. Its completion strobe is what the FSM waits on in its PIN, account-confirm and amount states.

---
 rtl/atm_keypad_entry.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM: buffers decimal keys, converts them to binary on ENTER, and strobes done/error.
// Optional idle-timeout abort is compiled in with `define KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
  parameter int          MAX_DIGITS     = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  entry_mode,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        busy,
  output logic [3:0]  digit_count,
  output logic [13:0] password,
  output logic [15:0] Pers_Account_No,
  output logic [31:0] amount,
  output logic        entry_done,
  output logic        entry_error,
  output logic [1:0]  error_code
);

  typedef enum logic [2:0] {IDLE, CLEAR_BUF, COLLECT, CONVERT, DONE, ERROR} state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  state_t      state, next_state;
  logic [1:0]  mode;
  logic [3:0]  digit_buf [MAX_DIGITS];
  logic [3:0]  conv_idx;
  logic [31:0] acc;
  logic [3:0]  limit;
  logic        len_ok;
  logic        out_of_range;
  logic        conv_last;
  logic        key_is_digit;
  logic        timeout_hit;

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] idle_cnt;
  assign timeout_hit = (idle_cnt >= TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    case (mode)
      2'b00:   limit = 4'd4;
      2'b01:   limit = 4'd5;
      default: limit = 4'(MAX_DIGITS);
    endcase
  end

  assign len_ok       = (mode == 2'b00) ? (digit_count == 4'd4) : (digit_count != 4'd0);
  assign out_of_range = ((mode == 2'b00) && (acc > 32'd9999)) ||
                        ((mode == 2'b01) && (acc > 32'd65535));
  assign conv_last    = (conv_idx == digit_count);
  assign key_is_digit = (key_code <= 4'd9);

  // busy stays high through the done/error pulse cycle, so it falls one cycle after it
  assign busy = (state != IDLE) || entry_done || entry_error;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = CLEAR_BUF;
      CLEAR_BUF: next_state = COLLECT;
      COLLECT: begin
        if (start)                                     next_state = CLEAR_BUF;
        else if (key_valid && (key_code == KEY_ENTER)) next_state = len_ok ? CONVERT : ERROR;
        else if (!key_valid && timeout_hit)            next_state = ERROR;
      end
      CONVERT:   if (conv_last) next_state = out_of_range ? ERROR : DONE;
      DONE:      next_state = IDLE;
      ERROR:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Digits are stored oldest-first at index 0, so conversion walks the buffer upward.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode            <= 2'b00;
      digit_count     <= 4'd0;
      conv_idx        <= 4'd0;
      acc             <= 32'd0;
      password        <= 14'd0;
      Pers_Account_No <= 16'd0;
      amount          <= 32'd0;
      entry_done      <= 1'b0;
      entry_error     <= 1'b0;
      error_code      <= 2'b00;
      for (int i = 0; i < MAX_DIGITS; i++) digit_buf[i] <= 4'd0;
`ifdef KEYPAD_TIMEOUT_EN
      idle_cnt        <= 32'd0;
`endif
    end else begin
      entry_done  <= 1'b0;
      entry_error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode       <= entry_mode;
            error_code <= 2'b00;
          end
        end
        CLEAR_BUF: begin
          for (int i = 0; i < MAX_DIGITS; i++) digit_buf[i] <= 4'd0;
          digit_count <= 4'd0;
`ifdef KEYPAD_TIMEOUT_EN
          idle_cnt    <= 32'd0;
`endif
        end
        COLLECT: begin
          if (start) begin
            mode       <= entry_mode;
            error_code <= 2'b00;
          end else if (key_valid) begin
`ifdef KEYPAD_TIMEOUT_EN
            idle_cnt <= 32'd0;
`endif
            if (key_is_digit) begin
              if (digit_count < limit) begin
                digit_buf[digit_count] <= key_code;
                digit_count            <= digit_count + 4'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              for (int i = 0; i < MAX_DIGITS; i++) digit_buf[i] <= 4'd0;
              digit_count <= 4'd0;
            end else if (key_code == KEY_BACK) begin
              if (digit_count != 4'd0) begin
                digit_buf[digit_count - 4'd1] <= 4'd0;
                digit_count                   <= digit_count - 4'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              acc      <= 32'd0;
              conv_idx <= 4'd0;
              if (!len_ok) error_code <= 2'b01;
            end
          end
`ifdef KEYPAD_TIMEOUT_EN
          else begin
            idle_cnt <= idle_cnt + 32'd1;
            if (timeout_hit) error_code <= 2'b11;
          end
`endif
        end
        CONVERT: begin
          if (!conv_last) begin
            acc      <= (acc << 3) + (acc << 1) + 32'(digit_buf[conv_idx]);
            conv_idx <= conv_idx + 4'd1;
          end else if (out_of_range) begin
            error_code <= 2'b10;
          end
        end
        DONE: begin
          entry_done <= 1'b1;
          case (mode)
            2'b00:   password        <= acc[13:0];
            2'b01:   Pers_Account_No <= acc[15:0];
            default: amount          <= acc;
          endcase
        end
        ERROR:   entry_error <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
